wb_fsmc_master: RTL and testbench

- Wishbone slave that issues FSMC (async SRAM-style, 16-bit, non-multiplexed) bus cycles as the host.
- Other end of the FSMC bus from the FSMC-to-Wishbone bridge.
- Used to drive the bridge in system simulation and loopback builds, and to talk to external async SRAM/FSMC peripherals from an on-chip Wishbone master.
- Timing is parameterised in clk cycles; one transfer in flight at a time.

---
 rtl/fsmc_pkg.sv | 23 ++
 rtl/fsmc_phase_timer.sv | 36 +++
 rtl/wb_fsmc_master.sv | 181 ++++++++++++++++++
 tb/tb_wb_fsmc_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsmc_pkg.sv
// rtl/fsmc_pkg.sv - shared FSMC bus widths, default timing and state encoding
// Shared by wb_fsmc_master and the FSMC-to-Wishbone bridge.
package fsmc_pkg;

   localparam int FSMC_AW = 16;
   localparam int FSMC_DW = 16;
   localparam int WB_AW   = 24;
   localparam int WB_DW   = 32;

   // Default DATAST covers the bridge's input synchroniser plus a zero-wait slave.
   localparam int FSMC_ADDSET_DEF  = 2;
   localparam int FSMC_DATAST_DEF  = 8;
   localparam int FSMC_BUSTURN_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_TURN   = 3'd4
   } fsmc_state_t;

endpackage

// File: rtl/fsmc_phase_timer.sv
// rtl/fsmc_phase_timer.sv - loadable down-counter timing each FSMC bus phase
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_val (has priority over dec)
//   load_val   : value loaded on load
//   dec        : decrement, saturating at zero
//   value      : current count
//   zero       : value == 0
module fsmc_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign value = cnt;
   assign zero  = (cnt == '0);

endmodule

// File: rtl/wb_fsmc_master.sv
// rtl/wb_fsmc_master.sv - Wishbone slave that runs async-SRAM style FSMC cycles as bus host
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   wb_*                  : Wishbone slave; adr[15:0], dat[15:0], sel[1:0] used
//   fsmc_adr, fsmc_dat_o  : FSMC address / write data (hold last value when idle)
//   fsmc_dat_i            : FSMC read data, captured on the last strobe cycle
//   fsmc_data_out_en      : tristate enable for fsmc_dat_o
//   fsmc_ce_n/we_n/oe_n   : chip enable, write strobe, read strobe
//   fsmc_ub_n/lb_n        : byte enables latched from ~wb_sel_i[1:0]
module wb_fsmc_master
   import fsmc_pkg::*;
#(
   parameter int ADDSET  = FSMC_ADDSET_DEF,
   parameter int DATAST  = FSMC_DATAST_DEF,
   parameter int BUSTURN = FSMC_BUSTURN_DEF,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WB_AW-1:0]   wb_adr_i,
   input  logic [WB_DW-1:0]   wb_dat_i,
   output logic [WB_DW-1:0]   wb_dat_o,
   input  logic [3:0]         wb_sel_i,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   input  logic               wb_we_i,
   output logic               wb_ack_o,
   output logic [FSMC_AW-1:0] fsmc_adr,
   output logic [FSMC_DW-1:0] fsmc_dat_o,
   input  logic [FSMC_DW-1:0] fsmc_dat_i,
   output logic               fsmc_data_out_en,
   output logic               fsmc_ce_n,
   output logic               fsmc_we_n,
   output logic               fsmc_oe_n,
   output logic               fsmc_ub_n,
   output logic               fsmc_lb_n
);

   localparam logic [CNT_W-1:0] ADDSET_M1  = CNT_W'(ADDSET - 1);
   localparam logic [CNT_W-1:0] DATAST_M1  = CNT_W'(DATAST - 1);
   localparam logic [CNT_W-1:0] BUSTURN_M1 = (BUSTURN == 0) ? '0 : CNT_W'(BUSTURN - 1);
   // With no turnaround the bus goes straight back to IDLE after HOLD or an abort.
   localparam fsmc_state_t AFTER_XFER = (BUSTURN == 0) ? ST_IDLE : ST_TURN;

   fsmc_state_t      state;
   logic             we_lat;
   logic             req;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_dec;
   logic [CNT_W-1:0] tmr_value;
   logic             tmr_zero;

   assign req = wb_cyc_i & wb_stb_i;

   fsmc_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .value    (tmr_value),
      .zero     (tmr_zero)
   );

   // Timer control mirrors the state transitions below: each phase entry loads its length.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_dec  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (req) begin
               tmr_load = 1'b1;
               tmr_val  = ADDSET_M1;
            end
         end
         ST_SETUP: begin
            if (!wb_cyc_i) begin
               tmr_load = 1'b1;
               tmr_val  = BUSTURN_M1;
            end else if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = DATAST_M1;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_STROBE: begin
            if (!wb_cyc_i) begin
               tmr_load = 1'b1;
               tmr_val  = BUSTURN_M1;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_HOLD: begin
            tmr_load = 1'b1;
            tmr_val  = BUSTURN_M1;
         end
         ST_TURN: tmr_dec = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         we_lat           <= 1'b0;
         wb_dat_o         <= '0;
         wb_ack_o         <= 1'b0;
         fsmc_adr         <= '0;
         fsmc_dat_o       <= '0;
         fsmc_data_out_en <= 1'b0;
         fsmc_ce_n        <= 1'b1;
         fsmc_we_n        <= 1'b1;
         fsmc_oe_n        <= 1'b1;
         fsmc_ub_n        <= 1'b1;
         fsmc_lb_n        <= 1'b1;
      end else begin
         wb_ack_o <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (req) begin
                  we_lat    <= wb_we_i;
                  fsmc_adr  <= wb_adr_i[FSMC_AW-1:0];
                  fsmc_ub_n <= ~wb_sel_i[1];
                  fsmc_lb_n <= ~wb_sel_i[0];
                  fsmc_ce_n <= 1'b0;
                  if (wb_we_i) begin
                     fsmc_dat_o       <= wb_dat_i[FSMC_DW-1:0];
                     fsmc_data_out_en <= 1'b1;
                  end
                  state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (!wb_cyc_i) begin
                  fsmc_ce_n        <= 1'b1;
                  fsmc_data_out_en <= 1'b0;
                  state            <= AFTER_XFER;
               end else if (tmr_zero) begin
                  if (we_lat) fsmc_we_n <= 1'b0;
                  else        fsmc_oe_n <= 1'b0;
                  state <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               // Abort wins over completion: a dropped cycle never acks.
               if (!wb_cyc_i) begin
                  fsmc_we_n        <= 1'b1;
                  fsmc_oe_n        <= 1'b1;
                  fsmc_ce_n        <= 1'b1;
                  fsmc_data_out_en <= 1'b0;
                  state            <= AFTER_XFER;
               end else if (tmr_zero) begin
                  fsmc_we_n <= 1'b1;
                  fsmc_oe_n <= 1'b1;
                  if (!we_lat) wb_dat_o <= {16'h0, fsmc_dat_i};
                  wb_ack_o <= 1'b1;
                  state    <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               fsmc_ce_n        <= 1'b1;
               fsmc_data_out_en <= 1'b0;
               state            <= AFTER_XFER;
            end
            ST_TURN: begin
               if (tmr_zero) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   logic unused_bits;
   assign unused_bits = ^{wb_adr_i[WB_AW-1:FSMC_AW], wb_dat_i[WB_DW-1:FSMC_DW],
                          wb_sel_i[3:2], tmr_value};

endmodule

// File: tb/tb_wb_fsmc_master.sv
// tb/tb_wb_fsmc_master.sv - directed vector bench for wb_fsmc_master
module tb_wb_fsmc_master;
   import fsmc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [15:0] bus_val;

   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic [15:0] fsmc_adr, fsmc_dat_o, fsmc_dat_i;
   logic        fsmc_data_out_en, fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n;

   logic [31:0] wb_dat_o_b;
   logic        wb_ack_o_b;
   logic [15:0] fsmc_adr_b, fsmc_dat_o_b, fsmc_dat_i_b;
   logic        fsmc_data_out_en_b, fsmc_ce_n_b, fsmc_we_n_b, fsmc_oe_n_b, fsmc_ub_n_b, fsmc_lb_n_b;

   always #5 clk = ~clk;

   // The peripheral only drives valid data while oe_n is low.
   assign fsmc_dat_i   = fsmc_oe_n   ? 16'hDEAD : bus_val;
   assign fsmc_dat_i_b = fsmc_oe_n_b ? 16'hDEAD : bus_val;

   wb_fsmc_master u_dut (
      .clk(clk), .rst(rst),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
      .fsmc_adr(fsmc_adr), .fsmc_dat_o(fsmc_dat_o), .fsmc_dat_i(fsmc_dat_i),
      .fsmc_data_out_en(fsmc_data_out_en), .fsmc_ce_n(fsmc_ce_n), .fsmc_we_n(fsmc_we_n),
      .fsmc_oe_n(fsmc_oe_n), .fsmc_ub_n(fsmc_ub_n), .fsmc_lb_n(fsmc_lb_n)
   );

   wb_fsmc_master #(.BUSTURN(0)) u_dut_bt0 (
      .clk(clk), .rst(rst),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o_b), .wb_sel_i(wb_sel_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o_b),
      .fsmc_adr(fsmc_adr_b), .fsmc_dat_o(fsmc_dat_o_b), .fsmc_dat_i(fsmc_dat_i_b),
      .fsmc_data_out_en(fsmc_data_out_en_b), .fsmc_ce_n(fsmc_ce_n_b), .fsmc_we_n(fsmc_we_n_b),
      .fsmc_oe_n(fsmc_oe_n_b), .fsmc_ub_n(fsmc_ub_n_b), .fsmc_lb_n(fsmc_lb_n_b)
   );

   typedef struct {
      logic        we;
      logic [23:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [15:0] rd;
      logic        drop_stb;
      logic [15:0] e_adr;
      logic [15:0] e_dat;
      logic        e_ub;
      logic        e_lb;
      logic [31:0] e_wb;
   } vec_t;

   vec_t vt[5];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock and sample outputs 1 time unit after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
   endtask

   // Sample index i reflects the state after the i-th edge following the request.
   task automatic run_vec(input int idx, input vec_t v);
      int ce_first = -1, stb_first = -1, stb_len = 0, ack_at = -1, ack_cnt = 0;
      int ce_low = 0, ce_high_after = 0;
      logic ok_adr = 1'b1, ok_dat = 1'b1, ok_doe = 1'b1, ok_be = 1'b1, ok_other = 1'b1;
      logic [31:0] wb_at_ack = '0;
      logic strobe_n, other_n;
      bus_val  = v.rd;
      wb_we_i  = v.we;
      wb_adr_i = v.adr;
      wb_dat_i = v.dat;
      wb_sel_i = v.sel;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         strobe_n = v.we ? fsmc_we_n : fsmc_oe_n;
         other_n  = v.we ? fsmc_oe_n : fsmc_we_n;
         if (!other_n) ok_other = 1'b0;
         if (!fsmc_ce_n) begin
            ce_low++;
            if (ce_first < 0) ce_first = i;
            if (fsmc_adr !== v.e_adr) ok_adr = 1'b0;
            if (fsmc_ub_n !== v.e_ub || fsmc_lb_n !== v.e_lb) ok_be = 1'b0;
            if (v.we && (fsmc_dat_o !== v.e_dat || !fsmc_data_out_en)) ok_dat = 1'b0;
            if (!v.we && fsmc_data_out_en) ok_doe = 1'b0;
         end
         if (!strobe_n) begin
            if (stb_first < 0) stb_first = i;
            stb_len++;
         end
         if (ack_at > 0 && i > ack_at && i <= ack_at + 2 && fsmc_ce_n) ce_high_after++;
         if (wb_ack_o) begin
            ack_cnt++;
            if (ack_at < 0) begin
               ack_at    = i;
               wb_at_ack = wb_dat_o;
            end
            idle_bus();
         end
         if (v.drop_stb && i == 4) wb_stb_i = 1'b0;
      end
      idle_bus();
      check($sformatf("v%0d ce_fall", idx), ce_first, 1);
      check($sformatf("v%0d strobe_start", idx), stb_first, 1 + FSMC_ADDSET_DEF);
      check($sformatf("v%0d strobe_len", idx), stb_len, FSMC_DATAST_DEF);
      check($sformatf("v%0d other_strobe_high", idx), ok_other, 1);
      check($sformatf("v%0d ack_cycle", idx), ack_at, 11);
      check($sformatf("v%0d ack_count", idx), ack_cnt, 1);
      check($sformatf("v%0d ce_low_len", idx), ce_low, 11);
      check($sformatf("v%0d adr_stable", idx), ok_adr, 1);
      check($sformatf("v%0d byte_en", idx), ok_be, 1);
      if (v.we) check($sformatf("v%0d wdata_stable", idx), ok_dat, 1);
      else      check($sformatf("v%0d doe_low", idx), ok_doe, 1);
      check($sformatf("v%0d wb_dat_o_at_ack", idx), wb_at_ack, v.e_wb);
      check($sformatf("v%0d ce_high_turn", idx), ce_high_after, 2);
   endtask

   initial begin
      int ce_fall, acks, a1, c2, a1b, c2b, ack2;
      logic pce, pceb;

      //      we    adr          dat           sel      rd        dstb  e_adr     e_dat     ub    lb    e_wb
      vt[0] = '{1'b1, 24'h001234, 32'h0000BEEF, 4'b0011, 16'h0000, 1'b0, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 32'h00000000};
      vt[1] = '{1'b0, 24'h00FF00, 32'h00000000, 4'b0011, 16'hA5C3, 1'b0, 16'hFF00, 16'h0000, 1'b0, 1'b0, 32'h0000A5C3};
      vt[2] = '{1'b1, 24'hAB5678, 32'hFFFF1111, 4'b0010, 16'h0000, 1'b0, 16'h5678, 16'h1111, 1'b0, 1'b1, 32'h0000A5C3};
      vt[3] = '{1'b0, 24'h000001, 32'h00000000, 4'b0000, 16'h0F0F, 1'b1, 16'h0001, 16'h0000, 1'b1, 1'b1, 32'h00000F0F};
      vt[4] = '{1'b0, 24'hFFFFFF, 32'h00000000, 4'b1101, 16'h8001, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 32'h00008001};

      rst = 1'b1;
      idle_bus();
      wb_we_i  = 1'b0;
      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_sel_i = '0;
      bus_val  = '0;
      repeat (3) step();
      check("reset ctrl {ce,we,oe,ub,lb,doe,ack}",
            {fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n, fsmc_data_out_en, wb_ack_o},
            7'b1111100);
      check("reset adr/dat", {fsmc_adr, fsmc_dat_o}, 32'h0);
      check("reset wb_dat_o", wb_dat_o, 32'h0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

      // Abort: drop cyc in the third strobe cycle of a read, then request a write at once.
      bus_val  = 16'h7777;
      wb_we_i  = 1'b0;
      wb_adr_i = 24'h000042;
      wb_sel_i = 4'b0011;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      acks = 0;
      for (int i = 1; i <= 5; i++) begin
         step();
         if (wb_ack_o) acks++;
      end
      check("abort in strobe", fsmc_oe_n, 1'b0);
      idle_bus();
      step();
      check("abort oe_n rises", fsmc_oe_n, 1'b1);
      check("abort ce_n rises", fsmc_ce_n, 1'b1);
      wb_we_i  = 1'b1;
      wb_adr_i = 24'h000099;
      wb_dat_i = 32'h00005555;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      ce_fall = -1;
      for (int i = 7; i <= 30 && ce_fall < 0; i++) begin
         step();
         if (wb_ack_o) acks++;
         if (!fsmc_ce_n) ce_fall = i;
      end
      check("abort no ack", acks, 0);
      check("abort wb_dat_o kept", wb_dat_o, 32'h00008001);
      check("abort turn then idle", ce_fall, 6 + FSMC_BUSTURN_DEF + 1);
      acks = 0;
      for (int i = 0; i < 20 && acks == 0; i++) begin
         step();
         if (wb_ack_o) begin
            acks++;
            idle_bus();
         end
      end
      check("post-abort write acked", acks, 1);
      idle_bus();
      repeat (6) step();

      // Back-to-back: write then read with cyc/stb held; the BUSTURN=0 build runs alongside.
      wb_we_i  = 1'b1;
      wb_adr_i = 24'h000010;
      wb_dat_i = 32'h00001234;
      wb_sel_i = 4'b0011;
      bus_val  = 16'h1234;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      a1 = -1; c2 = -1; a1b = -1; c2b = -1; ack2 = -1;
      pce = 1'b1; pceb = 1'b1;
      for (int i = 1; i <= 40 && ack2 < 0; i++) begin
         step();
         if (a1 > 0 && c2 < 0 && pce && !fsmc_ce_n) c2 = i;
         if (a1b > 0 && c2b < 0 && pceb && !fsmc_ce_n_b) c2b = i;
         if (wb_ack_o_b && a1b < 0) a1b = i;
         if (wb_ack_o) begin
            if (a1 < 0) begin
               a1 = i;
               wb_we_i = 1'b0;
            end else begin
               ack2 = i;
               idle_bus();
               check("b2b read data", wb_dat_o, 32'h00001234);
            end
         end
         pce  = fsmc_ce_n;
         pceb = fsmc_ce_n_b;
      end
      idle_bus();
      check("b2b first ack", a1, 11);
      check("b2b second ce gap", c2 - a1, FSMC_BUSTURN_DEF + 2);
      check("b2b busturn0 gap", c2b - a1b, 2);
      check("b2b second ack", ack2, a1 + FSMC_BUSTURN_DEF + 2 + 10);
      repeat (8) step();

      // Reset during SETUP of a write.
      wb_we_i  = 1'b1;
      wb_adr_i = 24'h000077;
      wb_dat_i = 32'h0000AAAA;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      step();
      step();
      check("rst-mid in setup", {fsmc_ce_n, fsmc_data_out_en}, 2'b01);
      rst = 1'b1;
      step();
      check("rst-mid ctrl {ce,we,oe,ub,lb,doe,ack}",
            {fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n, fsmc_data_out_en, wb_ack_o},
            7'b1111100);
      rst = 1'b0;
      idle_bus();
      acks = 0;
      pce = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         if (wb_ack_o) acks++;
         if (!fsmc_ce_n || !fsmc_we_n) pce = 1'b0;
      end
      check("rst-mid no ack", acks, 0);
      check("rst-mid bus stays idle", pce, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
